// File: rtl/ex_stage_mdu.sv
// ============================================================================
// ex_stage_mdu
// ----------------------------------------------------------------------------
// Execute stage with ALU, two-level operand forwarding (EX/MEM over WB), the
// EX/MEM pipeline register and an iterative multiply/divide unit that owns the
// HI/LO registers.
//
// Optional feature macro: EX_OVERFLOW_TRAP_EN
//   Defined   : adds registered output ovf. Signed overflow on ADD (funct 32)
//               or SUB (funct 34) sets ovf and squashes m_mem/wb_mem.
//               ADDU/SUBU (33/35) never trap.
//   Undefined : no ovf port; all adds/subtracts wrap silently.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid              ID/EX holds a real instruction
//   data_1, data_2        register-file operands rs, rt
//   imm                   sign-extended immediate, imm[5:0] = funct
//   rs, rt, rd            register specifiers
//   ex                    [3] RegDst, [2:1] ALU_op, [0] ALUSrc
//   m_ex, wb_ex           MEM / WB control (wb_ex[0] = RegWrite)
//   fwd_data_wb, rd_wb,
//   reg_write_wb          write-back forwarding source
//   stall                 combinational; upstream holds ID/EX while set
//   res, zero             registered result and result==0 flag
//   write_register        registered destination register
//   write_data_ex         registered forwarded rt value (store data)
//   m_mem, wb_mem         registered MEM / WB control
//   mdu_busy              registered; MDU iteration in progress
// ============================================================================
module ex_stage_mdu #(
    parameter int DATA_W         = 32,
    parameter int REG_AW         = 5,
    parameter int MDU_RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] imm,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [3:0]        ex,
    input  logic [2:0]        m_ex,
    input  logic [1:0]        wb_ex,
    input  logic [DATA_W-1:0] fwd_data_wb,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              reg_write_wb,
    output logic              stall,
    output logic [DATA_W-1:0] res,
    output logic              zero,
    output logic [REG_AW-1:0] write_register,
    output logic [DATA_W-1:0] write_data_ex,
    output logic [2:0]        m_mem,
    output logic [1:0]        wb_mem,
`ifdef EX_OVERFLOW_TRAP_EN
    output logic              ovf,
`endif
    output logic              mdu_busy
);

    localparam int STEPS = DATA_W / MDU_RADIX_BITS;
    localparam int CW    = $clog2(STEPS);
    localparam logic [CW-1:0]       CNT_LOAD = CW'(STEPS - 1);
    localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
    localparam logic [DATA_W-1:0]   ONES_W   = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0]   ONE_W    = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [2*DATA_W-1:0] ONE_2W   = {{(2*DATA_W-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0]   ZERO_R   = {REG_AW{1'b0}};

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_ADDU  = 6'd33;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_SUBU  = 6'd35;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_NOR   = 6'd39;
    localparam logic [5:0] F_SLT   = 6'd42;
    localparam logic [5:0] F_SLTU  = 6'd43;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} mdu_state_t;

    // MDU state
    mdu_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_acc_hi;     // product high half / partial remainder
    logic [DATA_W-1:0] r_acc_lo;     // multiplier bits / quotient bits
    logic [DATA_W-1:0] r_opnd;       // multiplicand / divisor magnitude
    logic [DATA_W-1:0] r_dividend;   // original dividend, for divide-by-zero
    logic              r_is_div;
    logic              r_neg_q;      // negate product / quotient at commit
    logic              r_neg_r;      // negate remainder at commit
    logic              r_dz;         // divide by zero
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    // Decode and datapath wires
    logic [5:0]        w_funct;
    logic [1:0]        w_alu_op;
    logic              w_rtype;
    logic              w_is_mdu;
    logic              w_is_mf;
    logic              w_is_mt;
    logic              w_accept;
    logic              w_start;
    logic              w_trap;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_slt;
    logic              w_sltu;
    logic [DATA_W-1:0] w_alu_res;
    logic [REG_AW-1:0] w_dest;
    logic              w_mdu_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W-1:0] w_step_hi;
    logic [DATA_W-1:0] w_step_lo;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W-1:0] w_sub;
    logic [DATA_W:0]   w_add;
    logic [2*DATA_W-1:0] w_prod;
    logic [2*DATA_W-1:0] w_prod_fin;
    logic [DATA_W-1:0] w_q_fin;
    logic [DATA_W-1:0] w_r_fin;

    assign w_funct  = imm[5:0];
    assign w_alu_op = ex[2:1];
    assign w_rtype  = (w_alu_op == 2'd2);
    assign w_is_mdu = w_rtype && ((w_funct == F_MULT) || (w_funct == F_MULTU) ||
                                  (w_funct == F_DIV)  || (w_funct == F_DIVU));
    assign w_is_mf  = w_rtype && ((w_funct == F_MFHI) || (w_funct == F_MFLO));
    assign w_is_mt  = w_rtype && ((w_funct == F_MTHI) || (w_funct == F_MTLO));

    assign stall    = in_valid & mdu_busy & (w_is_mdu | w_is_mf | w_is_mt);
    assign w_accept = in_valid & ~stall;
    assign w_start  = w_accept & w_is_mdu;

    // EX/MEM result beats the older WB result; register 0 never forwards.
    assign w_fwd_a = (wb_mem[0] && (write_register != ZERO_R) && (write_register == rs)) ? res :
                     (reg_write_wb && (rd_wb != ZERO_R) && (rd_wb == rs)) ? fwd_data_wb : data_1;
    assign w_fwd_b = (wb_mem[0] && (write_register != ZERO_R) && (write_register == rt)) ? res :
                     (reg_write_wb && (rd_wb != ZERO_R) && (rd_wb == rt)) ? fwd_data_wb : data_2;
    assign w_op_b  = ex[0] ? imm : w_fwd_b;
    assign w_dest  = ex[3] ? rd : rt;

    assign w_sum  = w_fwd_a + w_op_b;
    assign w_diff = w_fwd_a - w_op_b;
    assign w_slt  = ($signed(w_fwd_a) < $signed(w_op_b));
    assign w_sltu = (w_fwd_a < w_op_b);

`ifdef EX_OVERFLOW_TRAP_EN
    logic w_ovf_add;
    logic w_ovf_sub;
    assign w_ovf_add = (w_fwd_a[DATA_W-1] == w_op_b[DATA_W-1]) && (w_sum[DATA_W-1]  != w_fwd_a[DATA_W-1]);
    assign w_ovf_sub = (w_fwd_a[DATA_W-1] != w_op_b[DATA_W-1]) && (w_diff[DATA_W-1] != w_fwd_a[DATA_W-1]);
    assign w_trap    = w_rtype && (((w_funct == F_ADD) && w_ovf_add) || ((w_funct == F_SUB) && w_ovf_sub));
`else
    assign w_trap    = 1'b0;
`endif

    // ALU / MF* result selection
    always_comb begin
        w_alu_res = ZERO_W;
        case (w_alu_op)
            2'd0: w_alu_res = w_sum;
            2'd1: w_alu_res = w_diff;
            2'd2: begin
                case (w_funct)
                    F_ADD, F_ADDU: w_alu_res = w_sum;
                    F_SUB, F_SUBU: w_alu_res = w_diff;
                    F_AND:         w_alu_res = w_fwd_a & w_op_b;
                    F_OR:          w_alu_res = w_fwd_a | w_op_b;
                    F_NOR:         w_alu_res = ~(w_fwd_a | w_op_b);
                    F_SLT:         w_alu_res = {{(DATA_W-1){1'b0}}, w_slt};
                    F_SLTU:        w_alu_res = {{(DATA_W-1){1'b0}}, w_sltu};
                    F_MFHI:        w_alu_res = r_hi;
                    F_MFLO:        w_alu_res = r_lo;
                    default:       w_alu_res = ZERO_W;
                endcase
            end
            default: w_alu_res = ZERO_W;
        endcase
    end

    // Operand magnitudes: the MDU works unsigned and fixes signs at commit.
    assign w_mdu_signed = (w_funct == F_MULT) || (w_funct == F_DIV);
    assign w_a_neg = w_mdu_signed & w_fwd_a[DATA_W-1];
    assign w_b_neg = w_mdu_signed & w_fwd_b[DATA_W-1];
    assign w_a_mag = w_a_neg ? (~w_fwd_a + ONE_W) : w_fwd_a;
    assign w_b_mag = w_b_neg ? (~w_fwd_b + ONE_W) : w_fwd_b;

    // One MDU iteration: MDU_RADIX_BITS shift-add or restoring-divide steps
    always_comb begin
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        w_shift   = {(DATA_W+1){1'b0}};
        w_sub     = ZERO_W;
        w_add     = {(DATA_W+1){1'b0}};
        for (int i = 0; i < MDU_RADIX_BITS; i++) begin
            if (r_is_div) begin
                w_shift   = {w_step_hi, w_step_lo[DATA_W-1]};
                // Remainder < divisor, so the low DATA_W bits hold the exact difference.
                w_sub     = w_shift[DATA_W-1:0] - r_opnd;
                w_step_lo = {w_step_lo[DATA_W-2:0], (w_shift >= {1'b0, r_opnd})};
                if (w_shift >= {1'b0, r_opnd}) begin
                    w_step_hi = w_sub;
                end else begin
                    w_step_hi = w_shift[DATA_W-1:0];
                end
            end else begin
                w_add     = {1'b0, w_step_hi} + (w_step_lo[0] ? {1'b0, r_opnd} : {(DATA_W+1){1'b0}});
                w_step_lo = {w_add[0], w_step_lo[DATA_W-1:1]};
                w_step_hi = w_add[DATA_W:1];
            end
        end
    end

    // Sign correction and divide-by-zero override for the final HI/LO values.
    assign w_prod     = {w_step_hi, w_step_lo};
    assign w_prod_fin = r_neg_q ? (~w_prod + ONE_2W) : w_prod;
    assign w_q_fin    = r_dz ? ONES_W     : (r_neg_q ? (~w_step_lo + ONE_W) : w_step_lo);
    assign w_r_fin    = r_dz ? r_dividend : (r_neg_r ? (~w_step_hi + ONE_W) : w_step_hi);

    // MDU control FSM, iteration datapath and HI/LO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_acc_hi   <= ZERO_W;
            r_acc_lo   <= ZERO_W;
            r_opnd     <= ZERO_W;
            r_dividend <= ZERO_W;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_dz       <= 1'b0;
            r_hi       <= ZERO_W;
            r_lo       <= ZERO_W;
            mdu_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_RUN;
                        mdu_busy   <= 1'b1;
                        r_cnt      <= CNT_LOAD;
                        r_is_div   <= w_funct[1];
                        r_acc_hi   <= ZERO_W;
                        r_dividend <= w_fwd_a;
                        r_dz       <= w_funct[1] && (w_fwd_b == ZERO_W);
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        if (w_funct[1]) begin
                            r_acc_lo <= w_a_mag;
                            r_opnd   <= w_b_mag;
                        end else begin
                            r_acc_lo <= w_b_mag;
                            r_opnd   <= w_a_mag;
                        end
                    end else if (w_accept && w_is_mt) begin
                        if (w_funct == F_MTHI) begin
                            r_hi <= w_fwd_a;
                        end else begin
                            r_lo <= w_fwd_a;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    if (r_cnt == {CW{1'b0}}) begin
                        r_state  <= S_IDLE;
                        mdu_busy <= 1'b0;
                        if (r_is_div) begin
                            r_hi <= w_r_fin;
                            r_lo <= w_q_fin;
                        end else begin
                            r_hi <= w_prod_fin[2*DATA_W-1:DATA_W];
                            r_lo <= w_prod_fin[DATA_W-1:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    mdu_busy <= 1'b0;
                end
            endcase
        end
    end

    // EX/MEM pipeline register; stalls and invalid slots become bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res            <= ZERO_W;
            zero           <= 1'b0;
            write_register <= ZERO_R;
            write_data_ex  <= ZERO_W;
            m_mem          <= 3'b000;
            wb_mem         <= 2'b00;
`ifdef EX_OVERFLOW_TRAP_EN
            ovf            <= 1'b0;
`endif
        end else if (w_accept) begin
            res           <= w_alu_res;
            zero          <= (w_alu_res == ZERO_W);
            write_data_ex <= w_fwd_b;
            // MT* writes HI/LO only, so the destination register is left alone.
            if (w_is_mt) begin
                write_register <= write_register;
            end else begin
                write_register <= w_dest;
            end
            if (w_trap) begin
                m_mem  <= 3'b000;
                wb_mem <= 2'b00;
            end else begin
                m_mem  <= m_ex;
                wb_mem <= {wb_ex[1], wb_ex[0] & ~(w_is_mdu | w_is_mt)};
            end
`ifdef EX_OVERFLOW_TRAP_EN
            ovf <= w_trap;
`endif
        end else begin
            res            <= ZERO_W;
            zero           <= 1'b0;
            write_register <= w_dest;
            write_data_ex  <= w_fwd_b;
            m_mem          <= 3'b000;
            wb_mem         <= 2'b00;
`ifdef EX_OVERFLOW_TRAP_EN
            ovf            <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
module tb_ex_stage_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] data_1, data_2, imm;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  ex;
    logic [2:0]  m_ex;
    logic [1:0]  wb_ex;
    logic [31:0] fwd_data_wb;
    logic [4:0]  rd_wb;
    logic        reg_write_wb;
    logic        stall;
    logic [31:0] res;
    logic        zero;
    logic [4:0]  write_register;
    logic [31:0] write_data_ex;
    logic [2:0]  m_mem;
    logic [1:0]  wb_mem;
    logic        mdu_busy;
`ifdef EX_OVERFLOW_TRAP_EN
    logic        ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [3:0] R_T  = 4'b1100;  // RegDst, ALU_op=2, register operand
    localparam logic [3:0] I_T  = 4'b0001;  // ALU_op=0 (ADD), immediate operand
    localparam logic [3:0] S_T  = 4'b0010;  // ALU_op=1 (SUB), register operand
    localparam logic [3:0] Z_T  = 4'b1110;  // ALU_op=3
    localparam logic [2:0] MX   = 3'b101;
    localparam logic [1:0] WX   = 2'b01;

    ex_stage_mdu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .data_1(data_1), .data_2(data_2), .imm(imm),
        .rs(rs), .rt(rt), .rd(rd), .ex(ex), .m_ex(m_ex), .wb_ex(wb_ex),
        .fwd_data_wb(fwd_data_wb), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
        .stall(stall), .res(res), .zero(zero), .write_register(write_register),
        .write_data_ex(write_data_ex), .m_mem(m_mem), .wb_mem(wb_mem),
`ifdef EX_OVERFLOW_TRAP_EN
        .ovf(ovf),
`endif
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] d1, d2, im;
        logic [4:0]  s, t, d;
        logic [3:0]  e;
        logic [2:0]  m;
        logic [1:0]  w;
        logic [31:0] fwd;
        logic [4:0]  rdwb;
        logic        rwwb;
        logic [31:0] e_res;
        logic        e_zero;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [2:0]  e_m;
        logic [1:0]  e_wb;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] i, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic [3:0] e);
        in_valid = v; data_1 = a; data_2 = b; imm = i;
        rs = s; rt = t; rd = d; ex = e;
        m_ex = MX; wb_ex = WX;
        fwd_data_wb = 32'd0; rd_wb = 5'd0; reg_write_wb = 1'b0;
    endtask

    // Wait (bounded) for the MDU to finish while feeding bubbles.
    task automatic wait_idle(input string nm);
        int cnt;
        cnt = 0;
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        while (mdu_busy && cnt < 200) begin
            step();
            cnt++;
        end
        check(nm, {63'd0, mdu_busy}, 64'd0);
    endtask

    task automatic read_hilo(input string nm, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        set_in(1'b1, 32'd0, 32'd0, 32'd18, 5'd0, 5'd0, 5'd22, R_T);
        step();
        check({nm, "_lo"}, {32'd0, res}, {32'd0, exp_lo});
        set_in(1'b1, 32'd0, 32'd0, 32'd16, 5'd0, 5'd0, 5'd22, R_T);
        step();
        check({nm, "_hi"}, {32'd0, res}, {32'd0, exp_hi});
    endtask

    initial begin
        int cnt;
        //          vld  d1            d2            imm           rs     rt     rd     ex   m   w   fwd     rdwb  rwwb  e_res         z     wr     wd            em      ewb    ovf
        vecs[0]  = '{1'b1, 32'd5,        32'd7,        32'd32,       5'd1,  5'd2,  5'd3,  R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd12,       1'b0, 5'd3,  32'd7,        MX,     WX,    1'b0};
        vecs[1]  = '{1'b1, 32'd0,        32'd0,        32'd32,       5'd3,  5'd3,  5'd4,  R_T, MX, WX, 32'd99, 5'd3, 1'b1, 32'd24,       1'b0, 5'd4,  32'd12,       MX,     WX,    1'b0};
        vecs[2]  = '{1'b1, 32'd0,        32'd0,        32'd32,       5'd3,  5'd4,  5'd5,  R_T, MX, WX, 32'd99, 5'd3, 1'b1, 32'd123,      1'b0, 5'd5,  32'd24,       MX,     WX,    1'b0};
        vecs[3]  = '{1'b1, 32'd55,       32'd0,        32'd32,       5'd6,  5'd7,  5'd0,  R_T, MX, WX, 32'd77, 5'd0, 1'b1, 32'd55,       1'b0, 5'd0,  32'd0,        MX,     WX,    1'b0};
        vecs[4]  = '{1'b1, 32'd0,        32'd0,        32'd32,       5'd0,  5'd0,  5'd5,  R_T, MX, WX, 32'd77, 5'd0, 1'b1, 32'd0,        1'b1, 5'd5,  32'd0,        MX,     WX,    1'b0};
        vecs[5]  = '{1'b1, 32'd3,        32'd5,        32'd34,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'hFFFFFFFE, 1'b0, 5'd12, 32'd5,        MX,     WX,    1'b0};
        vecs[6]  = '{1'b1, 32'h0000F0F0, 32'h0000FF00, 32'd36,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'h0000F000, 1'b0, 5'd12, 32'h0000FF00, MX,     WX,    1'b0};
        vecs[7]  = '{1'b1, 32'h0000F0F0, 32'h00000F00, 32'd37,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'h0000FFF0, 1'b0, 5'd12, 32'h00000F00, MX,     WX,    1'b0};
        vecs[8]  = '{1'b1, 32'h0000FFFF, 32'hFFFF0000, 32'd39,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd0,        1'b1, 5'd12, 32'hFFFF0000, MX,     WX,    1'b0};
        vecs[9]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'd42,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd1,        1'b0, 5'd12, 32'd1,        MX,     WX,    1'b0};
        vecs[10] = '{1'b1, 32'hFFFFFFFF, 32'd1,        32'd43,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd0,        1'b1, 5'd12, 32'd1,        MX,     WX,    1'b0};
        vecs[11] = '{1'b1, 32'd10,       32'h1234,     32'hFFFFFFFD, 5'd10, 5'd13, 5'd12, I_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd7,        1'b0, 5'd13, 32'h1234,     MX,     WX,    1'b0};
        vecs[12] = '{1'b1, 32'd10,       32'd4,        32'd0,        5'd10, 5'd14, 5'd12, S_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd6,        1'b0, 5'd14, 32'd4,        MX,     WX,    1'b0};
        vecs[13] = '{1'b1, 32'd9,        32'd9,        32'd32,       5'd10, 5'd11, 5'd12, Z_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd0,        1'b1, 5'd12, 32'd9,        MX,     WX,    1'b0};
        vecs[14] = '{1'b1, 32'd9,        32'd9,        32'd1,        5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd0,        1'b1, 5'd12, 32'd9,        MX,     WX,    1'b0};
        vecs[15] = '{1'b0, 32'd9,        32'd9,        32'd32,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'd0,        1'b0, 5'd12, 32'd9,        3'b000, 2'b00, 1'b0};
        vecs[16] = '{1'b1, 32'h7FFFFFFF, 32'd1,        32'd33,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'h80000000, 1'b0, 5'd12, 32'd1,        MX,     WX,    1'b0};
`ifdef EX_OVERFLOW_TRAP_EN
        vecs[17] = '{1'b1, 32'h7FFFFFFF, 32'd1,        32'd32,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'h80000000, 1'b0, 5'd12, 32'd1,        3'b000, 2'b00, 1'b1};
`else
        vecs[17] = '{1'b1, 32'h7FFFFFFF, 32'd1,        32'd32,       5'd10, 5'd11, 5'd12, R_T, MX, WX, 32'd0,  5'd0, 1'b0, 32'h80000000, 1'b0, 5'd12, 32'd1,        MX,     WX,    1'b0};
`endif

        // Reset state
        rst_n = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'd0);
        #3;
        check("rst_res", {32'd0, res}, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd0);
        check("rst_wr", {59'd0, write_register}, 64'd0);
        check("rst_m_wb", {59'd0, m_mem, wb_mem}, 64'd0);
        check("rst_busy", {63'd0, mdu_busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].vld, vecs[i].d1, vecs[i].d2, vecs[i].im,
                   vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].e);
            m_ex = vecs[i].m; wb_ex = vecs[i].w;
            fwd_data_wb = vecs[i].fwd; rd_wb = vecs[i].rdwb; reg_write_wb = vecs[i].rwwb;
            check($sformatf("v%0d_stall", i), {63'd0, stall}, 64'd0);
            step();
            check($sformatf("v%0d_res", i), {32'd0, res}, {32'd0, vecs[i].e_res});
            check($sformatf("v%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].e_zero});
            check($sformatf("v%0d_wr", i), {59'd0, write_register}, {59'd0, vecs[i].e_wr});
            check($sformatf("v%0d_wdata", i), {32'd0, write_data_ex}, {32'd0, vecs[i].e_wd});
            check($sformatf("v%0d_m_wb", i), {59'd0, m_mem, wb_mem}, {59'd0, vecs[i].e_m, vecs[i].e_wb});
`ifdef EX_OVERFLOW_TRAP_EN
            check($sformatf("v%0d_ovf", i), {63'd0, ovf}, {63'd0, vecs[i].e_ovf});
`endif
        end

        // MTLO / MTHI then MFLO / MFHI
        set_in(1'b1, 32'h55, 32'd0, 32'd19, 5'd23, 5'd0, 5'd0, R_T);
        step();
        check("mtlo_wb", {62'd0, wb_mem}, 64'd0);
        set_in(1'b1, 32'hAA, 32'd0, 32'd17, 5'd23, 5'd0, 5'd0, R_T);
        step();
        read_hilo("mt", 32'h55, 32'hAA);

        // MULT -5 x 3 followed immediately by MFLO
        set_in(1'b1, 32'hFFFFFFFB, 32'd3, 32'd24, 5'd20, 5'd21, 5'd0, R_T);
        step();
        check("mult_busy", {63'd0, mdu_busy}, 64'd1);
        check("mult_wb", {62'd0, wb_mem}, 64'd0);
        set_in(1'b1, 32'd0, 32'd0, 32'd18, 5'd0, 5'd0, 5'd22, R_T);
        cnt = 0;
        while (stall && cnt < 100) begin
            step();
            cnt++;
        end
        check("mflo_stall_cycles", 64'(cnt), 64'd32);
        check("stall_bubble", {59'd0, m_mem, wb_mem}, 64'd0);
        step();
        check("mult_lo", {32'd0, res}, 64'hFFFFFFF1);
        check("mult_lo_wb", {62'd0, wb_mem}, 64'd1);
        set_in(1'b1, 32'd0, 32'd0, 32'd16, 5'd0, 5'd0, 5'd22, R_T);
        step();
        check("mult_hi", {32'd0, res}, 64'hFFFFFFFF);

        // DIVU 7 / 0
        set_in(1'b1, 32'd7, 32'd0, 32'd27, 5'd20, 5'd21, 5'd0, R_T);
        step();
        wait_idle("divu0_done");
        read_hilo("divu0", 32'hFFFFFFFF, 32'd7);

        // DIV -7 / 2, with a non-MDU ADD issued while busy
        set_in(1'b1, 32'hFFFFFFF9, 32'd2, 32'd26, 5'd20, 5'd21, 5'd0, R_T);
        step();
        set_in(1'b1, 32'd1, 32'd2, 32'd32, 5'd24, 5'd25, 5'd26, R_T);
        #1;
        check("add_nostall", {63'd0, stall}, 64'd0);
        step();
        check("add_busy_res", {32'd0, res}, 64'd3);
        check("add_busy_wb", {62'd0, wb_mem}, 64'd1);
        wait_idle("div_done");
        read_hilo("div", 32'hFFFFFFFD, 32'hFFFFFFFF);

        // DIV MIN / -1
        set_in(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'd26, 5'd20, 5'd21, 5'd0, R_T);
        step();
        wait_idle("divmin_done");
        read_hilo("divmin", 32'h80000000, 32'd0);

        // Reset halfway through a DIV
        set_in(1'b1, 32'd100, 32'd7, 32'd26, 5'd20, 5'd21, 5'd0, R_T);
        step();
        set_in(1'b1, 32'd0, 32'd0, 32'd18, 5'd0, 5'd0, 5'd22, R_T);
        repeat (15) step();
        check("mid_div_busy", {63'd0, mdu_busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, mdu_busy}, 64'd0);
        check("rst_mid_stall", {63'd0, stall}, 64'd0);
        check("rst_mid_res", {32'd0, res}, 64'd0);
        check("rst_mid_wr", {59'd0, write_register}, 64'd0);
        check("rst_mid_m_wb", {59'd0, m_mem, wb_mem}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_mflo", {32'd0, res}, 64'd0);
        check("rst_mflo_wb", {62'd0, wb_mem}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage_mdu.md
Name: ex_stage_mdu

Overview:
- Parametrised next-generation execute stage: ALU, two-level forwarding and EX/MEM pipeline register, plus an iterative multiply/divide unit (MDU) with HI/LO registers.
- Sits between the ID/EX and EX/MEM boundaries; drives MEM-stage operands and control.
- Adds MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, a stall handshake, and fixed-priority forwarding from both MEM and WB.

Parameters:
- DATA_W, 32, datapath width (even, >= 8)
- REG_AW, 5, register-address width
- MDU_RADIX_BITS, 1, quotient/product bits resolved per MDU cycle (1 or 2; must divide DATA_W)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a real instruction
- data_1, data_2  in  DATA_W  register-file operands rs, rt
- imm  in  DATA_W  sign-extended immediate; imm[5:0] is funct
- rs, rt, rd  in  REG_AW  register specifiers
- ex  in  4  [3] RegDst, [2:1] ALU_op, [0] ALUSrc
- m_ex  in  3  MEM control, passed through
- wb_ex  in  2  WB control; [0] RegWrite
- fwd_data_wb  in  DATA_W  result being written back in WB
- rd_wb  in  REG_AW  WB destination
- reg_write_wb  in  1  WB RegWrite
- stall  out  1  combinational; upstream holds ID/EX while 1
- res  out  DATA_W  registered ALU/MDU result
- zero  out  1  registered (ALU result == 0)
- write_register  out  REG_AW  registered destination
- write_data_ex  out  DATA_W  registered forwarded rt value, for stores
- m_mem  out  3  registered MEM control
- wb_mem  out  2  registered WB control
- mdu_busy  out  1  registered; MDU iteration in progress

Behaviour:
- Reset (async, rst_n=0): all registered outputs, HI, LO, MDU state and counter cleared to 0. Reset mid-MDU op aborts it; HI/LO read 0 afterwards.
- Forwarding, per operand:
  - EX/MEM source (res, write_register, wb_mem[0]) has priority over the WB source.
  - Never forward when the matching destination is 0.
  - If no match, use data_1/data_2.
  - op_b = ex[0] ? imm : forwarded rt.
  - write_data_ex captures the forwarded rt value, not raw data_2.
- ALU_op decode:
  - 0 ADD; 1 SUB.
  - 2 uses funct: 32 ADD, 34 SUB, 36 AND, 37 OR, 39 NOR, 42 SLT (signed), 43 SLTU.
  - 3, or unknown funct: result 0.
- Arithmetic: modulo 2^DATA_W, no traps (see Optional Feature).
- MDU instructions (ALU_op=2), funct 24/25/26/27 = MULT/MULTU/DIV/DIVU:
  - Start when in_valid & ~stall.
  - Busy for DATA_W/MDU_RADIX_BITS cycles; HI/LO written on the final cycle; mdu_busy drops the following cycle.
  - The instruction itself flows to MEM with wb_mem[0] forced 0.
- FSM: IDLE -> RUN on start, counter loaded with DATA_W/MDU_RADIX_BITS-1. RUN -> IDLE when counter hits 0 (HI/LO commit). A start in IDLE is never lost.
- MULT: {HI,LO} = full 2*DATA_W product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend.
  - Signed MIN/-1: LO = MIN, HI = 0.
- MFHI(16)/MFLO(18): result = HI/LO.
- MTHI(17)/MTLO(19): HI/LO <= forwarded rs at the clock edge; no write_register update.
- stall = in_valid & mdu_busy & (funct is any MDU op, MF*, or MT*).
  - While stall=1: EX/MEM captures a bubble (m_mem=0, wb_mem=0, res=0); inputs must be held.
  - Non-MDU instructions never stall.
- Latency: ALU ops 1 cycle to EX/MEM; MF* after an MDU op returns HI/LO one cycle after mdu_busy falls.
- in_valid=0: bubble (m_mem=0, wb_mem=0).

Optional Feature:
- Macro: EX_OVERFLOW_TRAP_EN.
- Defined:
  - Adds output ovf (1 bit, registered, reset 0).
  - Signed overflow on ADD (funct 32) or SUB (funct 34) sets ovf=1 for that instruction.
  - Forces wb_mem[0]=0 and m_mem=0 so no architectural write occurs.
  - ADDU(33)/SUBU(35) never trap.
- Undefined: no ovf port; 33/35 decode as ADD/SUB; wrap silently.

Test Plan:
- Forwarding priority: ADD r3 = 5 + 7, then ADD r4 = r3 + r3 while WB also writes r3 = 99 -> res = 24; EX/MEM source wins.
- Register 0 guard: prior op targets r0 with RegWrite=1, value 55; next op reads r0 with data_1=0 -> operand 0, no forward.
- MULT -5 x 3, then immediately MFLO:
  - MFLO stalls exactly DATA_W cycles, then res = 0xFFFFFFF1.
  - MFHI afterwards gives res = 0xFFFFFFFF.
- DIVU 7 / 0 -> LO = 0xFFFFFFFF, HI = 7. DIV -7 / 2 -> LO = -3, HI = -1.
- Reset asserted halfway through a DIV:
  - mdu_busy = 0, stall = 0, all outputs 0 immediately.
  - A subsequent MFLO returns 0.
- With EX_OVERFLOW_TRAP_EN: ADD 0x7FFFFFFF + 1 -> ovf = 1, wb_mem = 0. ADDU of the same operands -> res = 0x80000000, ovf = 0.
